// File: rtl/uart_loader_pkg.sv
// Shared types for the UART-to-RAM loader: loader and receiver state encodings
// and the word-packing geometry helper.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        L_IDLE   = 3'd0,
        L_LEN_HI = 3'd1,
        L_LEN_LO = 3'd2,
        L_DATA   = 3'd3,
        L_FIN    = 3'd4
    } load_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/uart_ram_loader_if.sv
// RAM second write port as seen from the loader (master) and the RAM (slave).
// wr_en is a one-cycle write strobe qualifying wr_addr/wr_data; the RAM is always ready, no backpressure.
interface uart_ram_loader_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, glitch-rejecting start check.
// byte_valid / frame_err are registered single-cycle pulses following the stop-bit sample.
module uart_rx_core
    import uart_loader_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      serial_in,
    output logic [7:0] rx_byte,
    output logic      byte_valid,
    output logic      frame_err,
    output rx_state_t rx_state
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    rx_state_t     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 2'b11;
            prev_q     <= 1'b1;
            state_q    <= R_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], serial_in};
            prev_q     <= sync_q[1];
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state_q)
                R_IDLE: begin
                    cnt_q <= '0;
                    if (prev_q && !sync_q[1]) state_q <= R_START;
                end
                R_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        // Line back high at mid-start: a glitch, not a frame.
                        state_q <= sync_q[1] ? R_IDLE : R_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {sync_q[1], shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) state_q <= R_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        state_q <= R_IDLE;
                        if (sync_q[1]) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shift_q;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= R_IDLE;
            endcase
        end
    end

    assign rx_state = state_q;

endmodule

// File: rtl/uart_ram_loader.sv
// Length-prefixed UART-to-RAM loader: 16-bit big-endian word count, then packed data
// bytes written to consecutive RAM addresses, with inter-byte timeout and sticky errors.
module uart_ram_loader
    import uart_loader_pkg::*;
#(
    parameter int CLK_DIV      = 868,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int BYTE_ORDER   = 0,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serial_in,
    input  logic                  arm,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    uart_ram_loader_if.master     ram,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           word_count,
    output logic                  err_frame,
    output logic                  err_timeout,
    output load_state_t           dbg_state,
    output rx_state_t             dbg_rx_state
);
    localparam int BPW       = bytes_per_word(DATA_WIDTH);
    localparam int IW        = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TMO_LIMIT = TIMEOUT_BITS * CLK_DIV;
    localparam int TW        = $clog2(TMO_LIMIT + 1);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;

    uart_rx_core #(.CLK_DIV(CLK_DIV)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .rx_state  (dbg_rx_state)
    );

    load_state_t           state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           len_q;
    logic [15:0]           wcnt_q;
    logic [IW-1:0]         idx_q;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  wr_en_q, busy_q, done_q, err_frame_q, err_timeout_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [IW-1:0]         lane;
    logic                  tmo_active, tmo_expired;

    always_comb begin
        lane   = (BYTE_ORDER != 0) ? (IW'(BPW - 1) - idx_q) : idx_q;
        word_d = word_q;
        word_d[8*lane +: 8] = rx_byte;
        // The host may idle before sending a length, so LEN_HI is never timed.
        tmo_active  = (state_q == L_LEN_LO) || (state_q == L_DATA);
        tmo_d       = (tmo_active && !byte_valid) ? tmo_q + 1'b1 : '0;
        tmo_expired = tmo_active && (tmo_q == TW'(TMO_LIMIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= L_IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            wcnt_q        <= '0;
            idx_q         <= '0;
            word_q        <= '0;
            tmo_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= tmo_d;
            if (arm) begin
                state_q       <= L_LEN_HI;
                addr_q        <= start_addr;
                wcnt_q        <= '0;
                idx_q         <= '0;
                word_q        <= '0;
                tmo_q         <= '0;
                busy_q        <= 1'b1;
                err_frame_q   <= 1'b0;
                err_timeout_q <= 1'b0;
            end else if (frame_err && state_q != L_IDLE) begin
                err_frame_q <= 1'b1;
                busy_q      <= 1'b0;
                state_q     <= L_IDLE;
            end else if (tmo_expired) begin
                err_timeout_q <= 1'b1;
                busy_q        <= 1'b0;
                state_q       <= L_IDLE;
            end else begin
                case (state_q)
                    L_IDLE: ;
                    L_LEN_HI: if (byte_valid) begin
                        len_q[15:8] <= rx_byte;
                        state_q     <= L_LEN_LO;
                    end
                    L_LEN_LO: if (byte_valid) begin
                        len_q[7:0] <= rx_byte;
                        if ({len_q[15:8], rx_byte} == 16'd0) begin
                            state_q <= L_FIN;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= L_DATA;
                        end
                    end
                    L_DATA: if (byte_valid) begin
                        if (idx_q == IW'(BPW - 1)) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr_q;
                            wr_data_q <= word_d;
                            addr_q    <= addr_q + 1'b1;
                            wcnt_q    <= wcnt_q + 16'd1;
                            idx_q     <= '0;
                            word_q    <= '0;
                            if (wcnt_q + 16'd1 == len_q) begin
                                state_q <= L_FIN;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            word_q <= word_d;
                            idx_q  <= idx_q + 1'b1;
                        end
                    end
                    L_FIN:   state_q <= L_IDLE;
                    default: state_q <= L_IDLE;
                endcase
            end
        end
    end

    assign ram.wr_en   = wr_en_q;
    assign ram.wr_addr = wr_addr_q;
    assign ram.wr_data = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign word_count  = wcnt_q;
    assign err_frame   = err_frame_q;
    assign err_timeout = err_timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Bench for uart_ram_loader: one little-endian and one big-endian instance share the
// serial line; expected RAM writes come from a byte-stream model of the protocol.
module tb_uart_ram_loader;
  import uart_loader_pkg::*;

  localparam int CLK_DIV = 16;
  localparam int DW      = 32;
  localparam int AW      = 12;
  localparam int W       = AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_in = 1'b1;
  logic arm = 1'b0;
  logic [AW-1:0] start_addr = '0;

  always #5 clk = ~clk;

  uart_ram_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram0 ();
  uart_ram_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ram1 ();

  logic        busy0, done0, ef0, et0, busy1, done1, ef1, et1;
  logic [15:0] wc0, wc1;
  load_state_t st0, st1;
  rx_state_t   rs0, rs1;

  uart_ram_loader #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                    .BYTE_ORDER(0), .TIMEOUT_BITS(64)) u_dut_le (
    .clk(clk), .rst(rst), .serial_in(serial_in), .arm(arm), .start_addr(start_addr),
    .ram(ram0), .busy(busy0), .done(done0), .word_count(wc0),
    .err_frame(ef0), .err_timeout(et0), .dbg_state(st0), .dbg_rx_state(rs0)
  );

  uart_ram_loader #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                    .BYTE_ORDER(1), .TIMEOUT_BITS(64)) u_dut_be (
    .clk(clk), .rst(rst), .serial_in(serial_in), .arm(arm), .start_addr(start_addr),
    .ram(ram1), .busy(busy1), .done(done1), .word_count(wc1),
    .err_frame(ef1), .err_timeout(et1), .dbg_state(st1), .dbg_rx_state(rs1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  int exp_done  = 0;
  logic [7:0] stream[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
    if (ram0.wr_en) begin
      if (exp_q0.size() == 0) check("wr_le_unexpected", 64'd1, 64'd0);
      else check("wr_le", {ram0.wr_addr, ram0.wr_data}, exp_q0.pop_front());
    end
    if (ram1.wr_en) begin
      if (exp_q1.size() == 0) check("wr_be_unexpected", 64'd1, 64'd0);
      else check("wr_be", {ram1.wr_addr, ram1.wr_data}, exp_q1.pop_front());
    end
  end

  // Reference: word w of a load is bytes 2+4w..5+4w; LE puts the first byte lowest.
  task automatic expect_words(input logic [AW-1:0] start, input int nwords);
    logic [AW-1:0] a;
    logic [7:0] b0, b1, b2, b3;
    for (int w = 0; w < nwords; w++) begin
      a  = start + AW'(w);
      b0 = stream[2+4*w]; b1 = stream[3+4*w]; b2 = stream[4+4*w]; b3 = stream[5+4*w];
      exp_q0.push_back({a, b3, b2, b1, b0});
      exp_q1.push_back({a, b0, b1, b2, b3});
    end
  endtask

  task automatic check_status(input string tag, input logic eb, input logic [15:0] ewc,
                              input logic eef, input logic eet);
    check({tag, "_busy_le"}, busy0, eb);
    check({tag, "_busy_be"}, busy1, eb);
    check({tag, "_wc_le"}, wc0, ewc);
    check({tag, "_wc_be"}, wc1, ewc);
    check({tag, "_ef_le"}, ef0, eef);
    check({tag, "_ef_be"}, ef1, eef);
    check({tag, "_et_le"}, et0, eet);
    check({tag, "_et_be"}, et1, eet);
  endtask

  task automatic check_done(input string tag);
    check({tag, "_done_le"}, done_cnt0, exp_done);
    check({tag, "_done_be"}, done_cnt1, exp_done);
    check({tag, "_pend_le"}, exp_q0.size(), 0);
    check({tag, "_pend_be"}, exp_q1.size(), 0);
  endtask

  // ---------------- drivers ----------------
  task automatic idle_bits(input int n);
    serial_in = 1'b1;
    repeat (n * CLK_DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    serial_in = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    serial_in = bad_stop ? 1'b0 : 1'b1;
    repeat (CLK_DIV) @(negedge clk);
    serial_in = 1'b1;
  endtask

  task automatic send_stream();
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(stream[i], 1'b0);
      idle_bits($urandom_range(0, 2));
    end
  endtask

  task automatic build_stream(input int len);
    stream.delete();
    stream.push_back(8'(len >> 8));
    stream.push_back(8'(len));
    for (int i = 0; i < 4 * len; i++) stream.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic do_arm(input logic [AW-1:0] a);
    @(negedge clk);
    start_addr = a;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic full_load(input string tag, input logic [AW-1:0] a, input int len);
    build_stream(len);
    do_arm(a);
    expect_words(a, len);
    exp_done++;
    send_stream();
    idle_bits(3);
    check_done(tag);
    check_status(tag, 1'b0, 16'(len), 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [AW-1:0] a_tmp;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_wr_en_le", ram0.wr_en, 1'b0);
    check("rst_wr_en_be", ram1.wr_en, 1'b0);
    check("rst_wr_addr", ram0.wr_addr, '0);
    check("rst_wr_data", ram0.wr_data, '0);
    check("rst_done", done0, 1'b0);
    check_status("rst", 1'b0, 16'd0, 1'b0, 1'b0);
    rst = 1'b0;
    idle_bits(2);

    // A byte while idle is discarded.
    send_byte(8'h5A, 1'b0);
    idle_bits(2);
    check_done("idle_byte");

    // Directed little/big-endian load.
    stream = '{8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_arm(12'h010);
    check("armed_busy", busy0, 1'b1);
    expect_words(12'h010, 2);
    check("model_le_w0", exp_q0[0], {12'h010, 32'h12345678});
    check("model_be_w1", exp_q1[1], {12'h011, 32'hEFBEADDE});
    exp_done++;
    send_stream();
    idle_bits(3);
    check_done("endian");
    check_status("endian", 1'b0, 16'd2, 1'b0, 1'b0);

    // Address wrap.
    full_load("wrap", 12'hFFF, 2);

    // Randomized loads.
    for (int n = 0; n < 4; n++) begin
      a_tmp = AW'($urandom_range(0, (1 << AW) - 1));
      full_load("rand", a_tmp, $urandom_range(1, 3));
    end

    // Glitch while waiting for the length, then a zero-length load.
    do_arm(12'h123);
    serial_in = 1'b0;
    repeat (CLK_DIV / 4) @(negedge clk);
    idle_bits(2);
    check("glitch_rx_idle", rs0, R_IDLE);
    check("glitch_state", st0, L_LEN_HI);
    stream = '{8'h00, 8'h00};
    exp_done++;
    send_stream();
    idle_bits(2);
    check_done("zero_len");
    check_status("zero_len", 1'b0, 16'd0, 1'b0, 1'b0);

    // Frame error on the third byte.
    do_arm(12'h200);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'hA5, 1'b1);
    idle_bits(3);
    check_done("frame");
    check_status("frame", 1'b0, 16'd0, 1'b1, 1'b0);

    // Timeout after the length; arm clears the frame error first.
    do_arm(12'h300);
    check_status("rearm1", 1'b1, 16'd0, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    idle_bits(65);
    check_done("timeout");
    check_status("timeout", 1'b0, 16'd0, 1'b0, 1'b1);
    do_arm(12'h300);
    check_status("rearm2", 1'b1, 16'd0, 1'b0, 1'b0);

    // Abort after 5 data bytes: one word written, fifth byte dropped.
    a_tmp = AW'($urandom_range(0, (1 << AW) - 1));
    build_stream(3);
    do_arm(a_tmp);
    expect_words(a_tmp, 1);
    for (int i = 0; i < 7; i++) send_byte(stream[i], 1'b0);
    idle_bits(1);
    check("abort_wc", wc0, 16'd1);
    a_tmp = a_tmp + AW'(100);
    full_load("after_abort", a_tmp, 1);

    // Reset mid-word.
    build_stream(2);
    do_arm(12'h0AB);
    for (int i = 0; i < 4; i++) send_byte(stream[i], 1'b0);
    serial_in = 1'b0;
    repeat (CLK_DIV + 5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_wr_addr", ram0.wr_addr, '0);
    check("rstmid_wr_data", ram1.wr_data, '0);
    check("rstmid_state", st0, L_IDLE);
    check_status("rstmid", 1'b0, 16'd0, 1'b0, 1'b0);
    serial_in = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    idle_bits(2);
    full_load("post_rst", 12'h7F0, 2);

    check_done("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_ram_loader.md
Name: uart_ram_loader

Overview:
- Parametrised successor to the fixed serial-to-RAM path in the top-level wrapper.
- Receives 8N1 UART bytes and packs them into DATA_WIDTH words; words are written to the RAM second write port at auto-incrementing addresses.
- Length-prefixed protocol, byte-order mode, inter-byte timeout and sticky error flags.
- Sits between the board serial pin and the RAM port-2 signals (wEn2/addr2/dataIn2); armed by the memory-map block.

Parameters:
- CLK_DIV, 868, clk cycles per UART bit (100 MHz / 115200); minimum 4.
- DATA_WIDTH, 32, RAM word width; must be a multiple of 8.
- ADDR_WIDTH, 12, RAM word-address width.
- BYTE_ORDER, 0, 0 = first byte is LSB of the word, 1 = first byte is MSB.
- TIMEOUT_BITS, 64, maximum idle gap between bytes during a load, in bit periods.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- serial_in  in  1  UART RX pin; asynchronous, idle high.
- arm  in  1  one-cycle pulse: latch start_addr, clear errors, begin a load.
- start_addr  in  ADDR_WIDTH  first word address.
- wr_en  out  1  RAM write strobe, one cycle per word.
- wr_addr  out  ADDR_WIDTH  RAM word address.
- wr_data  out  DATA_WIDTH  RAM write data.
- busy  out  1  high from arm until done or error.
- done  out  1  one-cycle pulse when the load completes.
- word_count  out  16  words written in the current/last load.
- err_frame  out  1  sticky: stop bit sampled low.
- err_timeout  out  1  sticky: inter-byte gap exceeded TIMEOUT_BITS.

Behaviour:
- Reset values: all outputs 0. FSM = IDLE; RX = IDLE; internal address/length/counters = 0.
- RX synchroniser: 2-FF on serial_in, reset value 1.
- RX start detect: falling edge of the synchronised input.
- RX start check: re-sample at CLK_DIV/2; if high, treat as a glitch and return to RX IDLE with no byte and no error.
- RX data: 8 data bits LSB-first, each sampled CLK_DIV after the previous sample.
- RX stop: stop bit sampled at its mid-point. byte_valid pulses that cycle; a low stop bit raises frame_err instead of byte_valid.
- RX runs continuously; bytes arriving in IDLE are discarded.
- Loader FSM states: IDLE, LEN_HI, LEN_LO, DATA, FIN.
- IDLE: on arm, go to LEN_HI. Latch addr=start_addr; clear word_count, err_*, byte index; busy=1 from the next cycle.
- LEN_HI / LEN_LO: byte_valid loads length[15:8], then length[7:0]. From LEN_LO, length==0 goes to FIN, otherwise DATA.
- DATA: each byte goes to lane idx (BYTE_ORDER 0) or lane BPW-1-idx (BYTE_ORDER 1), where BPW = DATA_WIDTH/8.
- DATA word completion: on the byte with idx==BPW-1, on the following cycle assert wr_en=1 with wr_addr=addr and wr_data=the packed word. Then addr+1 (wraps mod 2^ADDR_WIDTH), word_count+1, idx=0.
- DATA exit: when word_count reaches length, go to FIN on the same cycle as the final wr_en.
- FIN: done=1 for one cycle, busy=0, go to IDLE. word_count holds until the next arm.
- Timeout: counter clears on each byte_valid, active in LEN_LO and DATA (not LEN_HI: host may wait indefinitely). If the gap exceeds TIMEOUT_BITS*CLK_DIV cycles: err_timeout=1, busy=0, go to IDLE, no done.
- Frame error in any non-IDLE state: err_frame=1, busy=0, go to IDLE. The partial word is dropped; words already written remain.
- arm while busy: abort the current load, restart from LEN_HI with the new start_addr. No done pulse; a partial word is not written.
- arm in the same cycle as byte_valid: arm wins and the byte is discarded.
- rst mid-transfer: immediate return to reset values; an in-flight wr_en drops the same instant.
- wr_addr/wr_data hold their last values when wr_en=0.

Decomposition:
- Package uart_loader_pkg: loader state enum, RX state enum (R_IDLE, R_START, R_DATA, R_STOP), constant function bytes_per_word(DATA_WIDTH).
- Sub-module uart_rx_core (params CLK_DIV): synchroniser plus bit FSM. Outputs rx_byte[7:0], byte_valid, frame_err.
- Top: loader FSM, packing, address and timeout counters.

Test Plan:
- Little-endian load (sim CLK_DIV=16, BYTE_ORDER=0): arm start_addr=0x010; send 00 02 78 56 34 12 EF BE AD DE -> wr 0x12345678@0x010, 0xDEADBEEF@0x011; done pulse; word_count=2; busy=0.
- Big-endian: same stream with BYTE_ORDER=1 -> 0x78563412@0x010, 0xEFBEADDE@0x011.
- Address wrap: arm start_addr=0xFFF; send length 2 plus 8 bytes -> writes at 0xFFF then 0x000.
- Zero length and glitch: send 00 00 -> done 1 cycle after the second stop sample, no wr_en. A 0.25-bit low pulse in IDLE -> no byte, no error.
- Errors: stop bit forced low on byte 3 -> err_frame=1, busy=0, no wr_en. Separately, a gap of 65 bit periods after length -> err_timeout=1. Next arm clears both.
- Abort and reset: arm again after 5 data bytes -> the first word (4 bytes) is written; byte 5 is dropped; the new load starts at the new address. rst mid-word -> all outputs 0 asynchronously.
